// File: rtl/hs_arb_pkg.sv
// Shared types for the round-robin packet arbiter: FSM states and the
// buffered beat format carried through the output FIFO.
package hs_arb_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic                  last;
    } fifo_entry_t;

endpackage

// File: rtl/hs_fifo2.sv
// Two-entry synchronous FIFO. Entry storage is reset so the head reads as
// zero when the FIFO has never been written.
module hs_fifo2
    import hs_arb_pkg::*;
#(
    parameter type entry_t = fifo_entry_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  entry_t     push_entry,
    input  logic       pop,
    output entry_t     head,
    output logic       full,
    output logic       empty,
    output logic [1:0] count
);

    entry_t mem [2];
    logic   wr_ptr;
    logic   rd_ptr;
    logic   do_push;
    logic   do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // Simultaneous push and pop keeps the count.
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter merging NUM_SRC valid/ready packet sources into one
// sink; the grant is held for a whole packet and output is FIFO-buffered.
module hs_rr_arbiter
    import hs_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]        src_last,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic [DATA_W-1:0]         snk_data,
    output logic                      snk_last,
    output logic                      snk_valid,
    input  logic                      snk_ready,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } entry_t;

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [ID_W-1:0]   grant_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   rr_nxt;
    logic [DATA_W-1:0] sel_data;
    logic              sel_last;
    logic              sel_valid;
    logic              accept;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_count;
    entry_t            push_entry;
    entry_t            head;

    // First requester strictly after ptr, wrapping modulo NUM_SRC.
    function automatic logic [ID_W-1:0] rr_pick(input logic [ID_W-1:0]    ptr,
                                                input logic [NUM_SRC-1:0] req);
        logic [ID_W-1:0] cand;
        logic            found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = ID_W'((int'(ptr) + k) % NUM_SRC);
            if (!found && req[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        sel_data  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        src_ready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_data  = src_data[i*DATA_W +: DATA_W];
                sel_last  = src_last[i];
                sel_valid = src_valid[i];
            end
            // Ready depends only on registered state, never on snk_ready.
            src_ready[i] = (state == BUSY) && (grant_id == ID_W'(i)) && !fifo_full;
        end
    end

    assign accept     = (state == BUSY) && sel_valid && !fifo_full;
    assign push_entry = {sel_data, sel_last};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= ID_W'(NUM_SRC - 1);
        end else begin
            state    <= state_nxt;
            grant_id <= grant_nxt;
            rr_ptr   <= rr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        rr_nxt    = rr_ptr;
        case (state)
            IDLE: begin
                if (|src_valid) begin
                    grant_nxt = rr_pick(rr_ptr, src_valid);
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (accept && sel_last) begin
                    rr_nxt    = grant_id;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    assign busy = (state == BUSY);

    hs_fifo2 #(
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (accept),
        .push_entry (push_entry),
        .pop        (!fifo_empty && snk_ready),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    assign snk_valid = (fifo_count != 2'd0);
    assign snk_data  = head.data;
    assign snk_last  = head.last;

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Directed bench for hs_rr_arbiter with a queue-based reference model checked
// every cycle plus hand-computed expectations per scenario.
module tb_hs_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic [N*DW-1:0] src_data  = '0;
    logic [N-1:0]    src_last  = '0;
    logic [N-1:0]    src_valid = '0;
    logic [N-1:0]    src_ready;
    logic [DW-1:0]   snk_data;
    logic            snk_last;
    logic            snk_valid;
    logic            snk_ready;
    logic [IW-1:0]   grant_id;
    logic            busy;

    logic ready_raw = 1'b1;
    logic ready_q;
    logic use_reg   = 1'b0;
    int   ready_mode = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) ready_q <= ready_raw;
    assign snk_ready = use_reg ? ready_q : ready_raw;

    hs_rr_arbiter #(
        .NUM_SRC (N),
        .DATA_W  (DW),
        .ID_W    (IW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_data  (src_data),
        .src_last  (src_last),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .snk_data  (snk_data),
        .snk_last  (snk_last),
        .snk_valid (snk_valid),
        .snk_ready (snk_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          gap;
    } beat_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } ent_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          cyc;
    } log_t;

    beat_t srcq [N][$];
    ent_t  m_q[$];
    log_t  sink_log[$];

    int errors    = 0;
    int checks    = 0;
    int cyc       = 0;
    int full_seen = 0;
    bit m_busy    = 1'b0;
    int m_gid     = 0;
    int m_rr      = N - 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add_beat(input int s, input logic [31:0] d, input logic l, input int g);
        beat_t b;
        b.data = d;
        b.last = l;
        b.gap  = g;
        srcq[s].push_back(b);
    endtask

    function automatic bit all_idle();
        bit r;
        r = (m_q.size() == 0) && !m_busy && (src_valid == '0);
        for (int i = 0; i < N; i++) if (srcq[i].size() != 0) r = 1'b0;
        return r;
    endfunction

    // One clock cycle: compare at the falling edge, advance the model, then drive.
    task automatic step();
        logic [N-1:0] fire;
        logic [N-1:0] exp_rdy;
        bit           pop;
        bit           acc;
        ent_t         e;
        beat_t        b;
        @(negedge clk);
        cyc++;
        exp_rdy = '0;
        if (m_busy && m_q.size() < 2) exp_rdy[m_gid] = 1'b1;
        chk("src_ready", src_ready, exp_rdy);
        chk("busy", busy, m_busy);
        chk("grant_id", grant_id, 64'(m_gid));
        chk("snk_valid", snk_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            chk("snk_data", snk_data, m_q[0].data);
            chk("snk_last", snk_last, m_q[0].last);
        end
        if (m_q.size() == 2) begin
            full_seen++;
            chk("ready_while_full", |src_ready, 1'b0);
        end
        if (snk_valid && snk_ready) sink_log.push_back('{snk_data, snk_last, cyc});
        fire = src_valid & src_ready;

        pop = (m_q.size() > 0) && snk_ready;
        acc = m_busy && src_valid[m_gid] && (m_q.size() < 2);
        if (pop) void'(m_q.pop_front());
        if (acc) begin
            e.data = src_data[m_gid*DW +: DW];
            e.last = src_last[m_gid];
            m_q.push_back(e);
            if (e.last) begin
                m_rr   = m_gid;
                m_busy = 1'b0;
            end
        end else if (!m_busy && src_valid != '0) begin
            for (int k = 1; k <= N; k++) begin
                if (src_valid[(m_rr + k) % N]) begin
                    m_gid  = (m_rr + k) % N;
                    m_busy = 1'b1;
                    break;
                end
            end
        end

        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (fire[i]) void'(srcq[i].pop_front());
            if (srcq[i].size() > 0 && srcq[i][0].gap > 0) begin
                b = srcq[i][0];
                b.gap--;
                srcq[i][0] = b;
                src_valid[i] = 1'b0;
            end else if (srcq[i].size() > 0) begin
                src_valid[i]          = 1'b1;
                src_data[i*DW +: DW]  = srcq[i][0].data;
                src_last[i]           = srcq[i][0].last;
            end else begin
                src_valid[i] = 1'b0;
                src_last[i]  = 1'b0;
            end
        end
        case (ready_mode)
            0:       ready_raw = 1'b1;
            1:       ready_raw = ~ready_raw;
            default: ready_raw = 1'b0;
        endcase
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while (!all_idle() && n < max) begin
            step();
            n++;
        end
        step();
        step();
        chk("drain_within_budget", n < max, 1'b1);
    endtask

    // Asserts reset between clock edges and checks outputs before any edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_snk_valid", snk_valid, 1'b0);
        chk("rst_src_ready", src_ready, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant_id", grant_id, '0);
        chk("rst_snk_data", snk_data, '0);
        chk("rst_snk_last", snk_last, 1'b0);
        m_busy = 1'b0;
        m_gid  = 0;
        m_rr   = N - 1;
        m_q.delete();
        for (int i = 0; i < N; i++) srcq[i].delete();
        src_valid = '0;
        src_last  = '0;
        src_data  = '0;
        ready_raw = 1'b1;
        sink_log.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        #1;

        // Single source 2, three beats.
        do_reset();
        add_beat(2, 32'hA0, 1'b0, 0);
        add_beat(2, 32'hA1, 1'b0, 0);
        add_beat(2, 32'hA2, 1'b1, 0);
        step();
        chk("t1_ready_before_grant", src_ready, 4'b0000);
        step();
        chk("t1_ready_rise", src_ready, 4'b0100);
        chk("t1_grant", grant_id, 2'd2);
        step();
        chk("t1_first_valid", snk_valid, 1'b1);
        chk("t1_first_data", snk_data, 32'hA0);
        step();
        chk("t1_busy_mid", busy, 1'b1);
        step();
        chk("t1_busy_fall", busy, 1'b0);
        drain(20);
        chk("t1_count", sink_log.size(), 3);
        for (int j = 0; j < 3; j++) begin
            chk("t1_data", sink_log[j].data, 32'hA0 + j);
            chk("t1_last", sink_log[j].last, j == 2);
        end
        chk("t1_consecutive_a", sink_log[1].cyc - sink_log[0].cyc, 1);
        chk("t1_consecutive_b", sink_log[2].cyc - sink_log[1].cyc, 1);

        // All four sources with back-to-back single-beat packets.
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++) add_beat(i, 32'hB000 + i*16 + k, 1'b1, 0);
        drain(60);
        chk("t2_count", sink_log.size(), 8);
        for (int j = 0; j < 8; j++) chk("t2_order", sink_log[j].data, 32'hB000 + (j % 4)*16 + j/4);
        for (int j = 1; j < 8; j++) chk("t2_spacing", sink_log[j].cyc - sink_log[j-1].cyc, 2);

        // Registered, toggling sink ready with an 8-beat packet.
        do_reset();
        use_reg    = 1'b1;
        ready_mode = 1;
        full_seen  = 0;
        for (int j = 0; j < 8; j++) add_beat(0, 32'hC0 + j, j == 7, 0);
        drain(80);
        chk("t3_count", sink_log.size(), 8);
        for (int j = 0; j < 8; j++) begin
            chk("t3_data", sink_log[j].data, 32'hC0 + j);
            chk("t3_last", sink_log[j].last, j == 7);
        end
        chk("t3_full_reached", full_seen > 0, 1'b1);
        use_reg    = 1'b0;
        ready_mode = 0;

        // Source 1 stalls mid-packet while source 3 waits.
        do_reset();
        add_beat(1, 32'hB0, 1'b0, 0);
        add_beat(1, 32'hB1, 1'b0, 0);
        add_beat(1, 32'hB2, 1'b0, 3);
        add_beat(1, 32'hB3, 1'b1, 0);
        add_beat(3, 32'hD0, 1'b0, 0);
        add_beat(3, 32'hD1, 1'b1, 0);
        for (int n = 0; n < 40 && !all_idle(); n++) begin
            step();
            if (srcq[1].size() > 0 && srcq[1].size() < 4 && !src_valid[1]) begin
                chk("t4_grant_held", grant_id, 2'd1);
                chk("t4_busy_held", busy, 1'b1);
            end
        end
        drain(10);
        chk("t4_count", sink_log.size(), 6);
        for (int j = 0; j < 4; j++) chk("t4_src1_data", sink_log[j].data, 32'hB0 + j);
        chk("t4_src3_data0", sink_log[4].data, 32'hD0);
        chk("t4_src3_data1", sink_log[5].data, 32'hD1);
        chk("t4_one_bubble", sink_log[4].cyc - sink_log[3].cyc, 2);

        // Reset while busy with a full FIFO.
        do_reset();
        ready_mode = 2;
        ready_raw  = 1'b0;
        add_beat(0, 32'hE0, 1'b1, 0);
        for (int j = 0; j < 4; j++) add_beat(1, 32'hF0 + j, j == 3, 0);
        for (int n = 0; n < 20 && !(m_q.size() == 2 && m_busy); n++) step();
        chk("t5_setup_full_busy", m_q.size() == 2 && m_busy, 1'b1);
        chk("t5_pre_valid", snk_valid, 1'b1);
        chk("t5_pre_busy", busy, 1'b1);
        chk("t5_pre_grant", grant_id, 2'd1);
        ready_mode = 0;
        do_reset();
        add_beat(0, 32'h60, 1'b1, 0);
        add_beat(1, 32'h61, 1'b1, 0);
        drain(20);
        chk("t5_count", sink_log.size(), 2);
        chk("t5_src0_first", sink_log[0].data, 32'h60);
        chk("t5_src1_second", sink_log[1].data, 32'h61);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
